// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the MixColumns datapath.
// Used by inv_mix_column and multiplica_colunas (MULTIPLICA_COLUNAS_FWD_EN adds forward mode there).
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [127:0] aes_block_t;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic aes_byte_t xtime(input aes_byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// One AES column through the inverse MixColumns matrix, purely combinational.
// With MULTIPLICA_COLUNAS_FWD_EN defined, fwd_i = 1 selects the forward matrix instead.
module inv_mix_column
    import aes_pkg::*;
(
`ifdef MULTIPLICA_COLUNAS_FWD_EN
    input  logic        fwd_i,
`endif
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    aes_byte_t a   [4];
    aes_byte_t x2  [4];
    aes_byte_t x4  [4];
    aes_byte_t x8  [4];
    aes_byte_t m09 [4];
    aes_byte_t m0b [4];
    aes_byte_t m0d [4];
    aes_byte_t m0e [4];
    aes_byte_t b   [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            // a0 sits in the most significant byte of the column word.
            assign a[gi]   = col_i[31-8*gi -: 8];
            assign x2[gi]  = xtime(a[gi]);
            assign x4[gi]  = xtime(x2[gi]);
            assign x8[gi]  = xtime(x4[gi]);
            assign m09[gi] = x8[gi] ^ a[gi];
            assign m0b[gi] = x8[gi] ^ x2[gi] ^ a[gi];
            assign m0d[gi] = x8[gi] ^ x4[gi] ^ a[gi];
            assign m0e[gi] = x8[gi] ^ x4[gi] ^ x2[gi];
        end

        for (gi = 0; gi < 4; gi++) begin : g_row
            aes_byte_t inv_b;
            assign inv_b = m0e[gi] ^ m0b[(gi+1)%4] ^ m0d[(gi+2)%4] ^ m09[(gi+3)%4];
`ifdef MULTIPLICA_COLUNAS_FWD_EN
            aes_byte_t fwd_b;
            assign fwd_b = x2[gi] ^ x2[(gi+1)%4] ^ a[(gi+1)%4] ^ a[(gi+2)%4] ^ a[(gi+3)%4];
            assign b[gi] = fwd_i ? fwd_b : inv_b;
`else
            assign b[gi] = inv_b;
`endif
            assign col_o[31-8*gi -: 8] = b[gi];
        end
    endgenerate

endmodule

// File: rtl/multiplica_colunas.sv
// AES (inverse) MixColumns stage: four parallel columns plus one output register.
// Optional feature: MULTIPLICA_COLUNAS_FWD_EN adds the fwd port for forward MixColumns.
module multiplica_colunas
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
`ifdef MULTIPLICA_COLUNAS_FWD_EN
    input  logic         fwd,
`endif
    input  logic         in_valid,
    input  logic [127:0] bloco,
    output logic         out_valid,
    output logic [127:0] saida
);

    aes_block_t mixed;
    aes_block_t saida_d, saida_q;
    logic       out_valid_d, out_valid_q;

    genvar gi;
    generate
        // Column j gathers bytes j, j+4, j+8, j+12 of the block.
        for (gi = 0; gi < 4; gi++) begin : g_col
            logic [31:0] col_in, col_out;
            assign col_in = {bloco[127-8*gi -: 8],      bloco[127-8*(gi+4) -: 8],
                             bloco[127-8*(gi+8) -: 8],  bloco[127-8*(gi+12) -: 8]};

            inv_mix_column u_col (
`ifdef MULTIPLICA_COLUNAS_FWD_EN
                .fwd_i (fwd),
`endif
                .col_i (col_in),
                .col_o (col_out)
            );

            assign mixed[127-8*gi -: 8]      = col_out[31:24];
            assign mixed[127-8*(gi+4) -: 8]  = col_out[23:16];
            assign mixed[127-8*(gi+8) -: 8]  = col_out[15:8];
            assign mixed[127-8*(gi+12) -: 8] = col_out[7:0];
        end
    endgenerate

    always_comb begin
        saida_d     = in_valid ? mixed : saida_q;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saida_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            saida_q     <= saida_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign saida     = saida_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplica_colunas.sv
// Scoreboard bench for multiplica_colunas; forward-mode cases run when MULTIPLICA_COLUNAS_FWD_EN is defined.
module tb_multiplica_colunas;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] bloco = '0;
    logic         out_valid;
    logic [127:0] saida;
`ifdef MULTIPLICA_COLUNAS_FWD_EN
    logic         fwd = 1'b0;
`endif

    logic [127:0] exp_q [$];
    logic [127:0] last_out = '0;
    int           n_checks = 0;
    int           n_pass   = 0;

    always #5 clk = ~clk;

    multiplica_colunas dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MULTIPLICA_COLUNAS_FWD_EN
        .fwd       (fwd),
`endif
        .in_valid  (in_valid),
        .bloco     (bloco),
        .out_valid (out_valid),
        .saida     (saida)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %032h expected %032h", tag, got, exp);
    endtask

    // Reference: textbook shift-and-add GF(2^8) product with full 0x11B reduction.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] acc = 8'h00;
        logic [7:0] p = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) acc ^= p;
            p = p[7] ? ((p << 1) ^ 8'h1B) : (p << 1);
        end
        return acc;
    endfunction

    function automatic logic [7:0] coef(input int d, input bit fw);
        case (d)
            0:       return fw ? 8'h02 : 8'h0e;
            1:       return fw ? 8'h03 : 8'h0b;
            2:       return fw ? 8'h01 : 8'h0d;
            default: return fw ? 8'h01 : 8'h09;
        endcase
    endfunction

    function automatic logic [127:0] model(input logic [127:0] blk, input bit fw);
        logic [127:0] r = '0;
        for (int j = 0; j < 4; j++)
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc = 8'h00;
                for (int c = 0; c < 4; c++)
                    acc ^= gf_mul(coef((c - row + 4) % 4, fw), blk[127-8*(j+4*c) -: 8]);
                r[127-8*(j+4*row) -: 8] = acc;
            end
        return r;
    endfunction

    // One clock of stimulus; the result after the edge is compared against the scoreboard.
    task automatic cycle(input string tag, input bit v, input logic [127:0] blk,
                         input logic [127:0] exp, input bit fw);
        @(negedge clk);
        in_valid = v;
        bloco    = blk;
`ifdef MULTIPLICA_COLUNAS_FWD_EN
        fwd      = fw;
`endif
        if (v) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (v) begin
            check_eq({tag, "_valid"}, {127'b0, out_valid}, 128'd1);
            if (exp_q.size() == 0) check_eq({tag, "_sb_empty"}, 128'd1, 128'd0);
            else check_eq(tag, saida, exp_q.pop_front());
        end else begin
            check_eq({tag, "_valid"}, {127'b0, out_valid}, 128'd0);
            check_eq({tag, "_hold"}, saida, last_out);
        end
        $display("txn %-10s in_valid=%0d bloco=%032h saida=%032h out_valid=%0d",
                 tag, v, blk, saida, out_valid);
        last_out = saida;
    endtask

    initial begin
        logic [127:0] r;
        logic [127:0] mid;

        #12;
        check_eq("rst_saida", saida, 128'h0);
        check_eq("rst_valid", {127'b0, out_valid}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        cycle("mixed", 1'b1, 128'h200a0157414a0b253c1d1052414c1d3e,
              128'h6e4f6e4947655a494a7a71707f41426e, 1'b0);
        cycle("column", 1'b1, 128'h8e0000004d000000a1000000bc000000,
              128'hdb000000130000005300000045000000, 1'b0);
        cycle("zero", 1'b1, 128'h0, 128'h0, 1'b0);
        cycle("ones", 1'b1, {16{8'h01}}, {16{8'h01}}, 1'b0);

        for (int i = 0; i < 3; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            cycle("stream", 1'b1, r, model(r, 1'b0), 1'b0);
        end
        cycle("gap", 1'b0, 128'hdeadbeef, 128'h0, 1'b0);
        cycle("gap2", 1'b0, 128'h12345678, 128'h0, 1'b0);

        // Reset while a valid block is being presented: it must be discarded.
        @(negedge clk);
        in_valid = 1'b1;
        bloco    = 128'hffeeddccbbaa99887766554433221100;
        rst_n    = 1'b0;
        #1;
        check_eq("midrst_saida", saida, 128'h0);
        check_eq("midrst_valid", {127'b0, out_valid}, 128'd0);
        @(posedge clk);
        #1;
        check_eq("inrst_valid", {127'b0, out_valid}, 128'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        last_out = 128'h0;
        cycle("post_rst", 1'b1, 128'h8e0000004d000000a1000000bc000000,
              128'hdb000000130000005300000045000000, 1'b0);
        cycle("idle", 1'b0, 128'h0, 128'h0, 1'b0);

`ifdef MULTIPLICA_COLUNAS_FWD_EN
        cycle("fwd_col", 1'b1, 128'hdb000000130000005300000045000000,
              128'h8e0000004d000000a1000000bc000000, 1'b1);
        r = {$urandom, $urandom, $urandom, $urandom};
        cycle("fwd_rand", 1'b1, r, model(r, 1'b1), 1'b1);
        mid = last_out;
        cycle("roundtrip", 1'b1, mid, r, 1'b0);
`endif

        if (exp_q.size() != 0) check_eq("sb_leftover", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
